// File: rtl/fft_in_xbar.sv
// fft_in_xbar: remaps 8 memory-bank lanes onto 12 FFT PE lanes per radix, through a 2-entry output FIFO.
// Define FFT_IN_XBAR_BYPASS_EN to accept point==0 as an identity (bank k -> PE k) mode.
module fft_in_xbar #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2:0]              point,
    input  logic                    point_2_mode,
    input  logic [LEN_W-1:0]        frame_len,
    input  logic                    flush,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    input  logic [8*DATA_WIDTH-1:0] mem_out,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [12*DATA_WIDTH-1:0] fft_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);
    localparam int DW = DATA_WIDTH;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;
    logic [2:0] pt;
    logic p2m;
    logic [LEN_W-1:0] flen, cnt;
    logic [12*DW-1:0] f0, f1, mapped;
    logic l0, l1;
    logic [1:0] fc;
    logic legal, acc, pop, last_acc, launch;
    logic [DW-1:0] b [8];
    logic [DW-1:0] pe [12];

`ifdef FFT_IN_XBAR_BYPASS_EN
    assign legal = frame_len != '0 && point inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
`else
    assign legal = frame_len != '0 && point inside {3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
`endif
    assign launch    = state == IDLE && start && legal;
    assign busy      = state != IDLE;
    assign out_valid = fc != 2'd0;
    assign out_last  = out_valid && l0;
    assign fft_in    = out_valid ? f0 : '0;
    assign in_ready  = state == RUN && cnt < flen && !fc[1];
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign last_acc  = acc && cnt == flen - 1'b1;

    always_comb begin
        pe = '{default: '0};
        for (int k = 0; k < 8; k++) b[k] = mem_out[k*DW +: DW];
        case (pt)
            3'd7: begin
                pe[0] = b[0]; pe[1] = b[1]; pe[2] = b[6]; pe[3] = b[4];
                pe[4] = b[3]; pe[5] = b[2]; pe[6] = b[5];
            end
            3'd5: begin
                pe[0] = b[0]; pe[1] = b[1]; pe[2] = b[4]; pe[3] = b[3]; pe[4] = b[2];
            end
            3'd4: begin
                pe[1] = b[0]; pe[2] = b[2]; pe[5] = b[1]; pe[6] = b[3];
            end
            3'd3: begin
                pe[0] = b[0]; pe[1] = b[1]; pe[2] = b[2];
                pe[5] = b[4]; pe[6] = b[5]; pe[7] = b[3];
            end
            3'd2: begin
                pe[1] = b[0]; pe[2] = b[1]; pe[5] = b[2]; pe[6] = b[3];
                pe[8] = b[4]; pe[9] = b[5];
                pe[10] = p2m ? b[6] : '0;
                pe[11] = p2m ? b[7] : '0;
            end
`ifdef FFT_IN_XBAR_BYPASS_EN
            3'd0: for (int k = 0; k < 8; k++) pe[k] = b[k];
`endif
            default: ;
        endcase
        for (int j = 0; j < 12; j++) mapped[j*DW +: DW] = pe[j];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = launch ? RUN : IDLE;
            RUN:     state_nx = last_acc ? DRAIN : RUN;
            DRAIN:   state_nx = (pop && l0) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pt      <= '0;
            p2m     <= 1'b0;
            flen    <= '0;
            cnt     <= '0;
            fc      <= '0;
            l0      <= 1'b0;
            l1      <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nx;
            done    <= !flush && state == DRAIN && pop && l0;
            cfg_err <= !flush && state == IDLE && start && !legal;
            if (launch && !flush) begin
                pt   <= point;
                p2m  <= point_2_mode;
                flen <= frame_len;
            end
            if (flush) begin
                fc  <= '0;
                cnt <= '0;
            end else begin
                cnt <= launch ? '0 : cnt + LEN_W'(acc);
                if (pop) begin
                    f0 <= f1;
                    l0 <= l1;
                end
                // An entry pushed while the sole entry leaves must land at the head.
                if (acc && (fc == 2'd0 || pop)) begin
                    f0 <= mapped;
                    l0 <= last_acc;
                end else if (acc) begin
                    f1 <= mapped;
                    l1 <= last_acc;
                end
                fc <= fc + 2'(acc) - 2'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fft_in_xbar.sv
// tb_fft_in_xbar: directed checks of fft_in_xbar mappings, flow control, config errors and aborts.
module tb_fft_in_xbar;
    localparam int DW = 32;
    localparam int LW = 10;
    logic clk = 1'b0;
    logic rst, start, point_2_mode, flush, in_valid, out_ready;
    logic [2:0] point;
    logic [LW-1:0] frame_len;
    logic busy, done, cfg_err, in_ready, out_valid, out_last;
    logic [8*DW-1:0] mem_out;
    logic [12*DW-1:0] fft_in;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_in_xbar #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .point(point), .point_2_mode(point_2_mode),
        .frame_len(frame_len), .flush(flush), .busy(busy), .done(done), .cfg_err(cfg_err),
        .mem_out(mem_out), .in_valid(in_valid), .in_ready(in_ready), .fft_in(fft_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    task automatic chk(input string tag, input logic [12*DW-1:0] obs, input logic [12*DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Beat j carries value j*16+k+1 on bank k, so beat 0 is bank k = k+1.
    function automatic logic [8*DW-1:0] bank(input int j);
        logic [8*DW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*DW +: DW] = DW'(j*16 + k + 1);
        return r;
    endfunction

    // Source bank for each PE lane, -1 meaning the lane is zero.
    function automatic int src(input int p, input bit m, input int e);
        int t7[12] = '{0, 1, 6, 4, 3, 2, 5, -1, -1, -1, -1, -1};
        int t5[12] = '{0, 1, 4, 3, 2, -1, -1, -1, -1, -1, -1, -1};
        int t4[12] = '{-1, 0, 2, -1, -1, 1, 3, -1, -1, -1, -1, -1};
        int t3[12] = '{0, 1, 2, -1, -1, 4, 5, 3, -1, -1, -1, -1};
        int t2[12] = '{-1, 0, 1, -1, -1, 2, 3, -1, 4, 5, 6, 7};
        case (p)
            7: return t7[e];
            5: return t5[e];
            4: return t4[e];
            3: return t3[e];
            2: return (e >= 10 && !m) ? -1 : t2[e];
            0: return e < 8 ? e : -1;
            default: return -1;
        endcase
    endfunction

    function automatic logic [12*DW-1:0] expv(input int p, input bit m, input int j);
        logic [12*DW-1:0] r;
        int s;
        for (int e = 0; e < 12; e++) begin
            s = src(p, m, e);
            r[e*DW +: DW] = s < 0 ? '0 : DW'(j*16 + s + 1);
        end
        return r;
    endfunction

    task automatic run_frame(input int p, input bit m, input int len, input bit tog, input int chg);
        int fc = 0;
        int ib = 0;
        int ob = 0;
        bit dexp = 0;
        bit fin = 0;
        bit a, pp;
        point = 3'(p);
        point_2_mode = m;
        frame_len = LW'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start", busy, 1);
        for (int c = 0; c < 200 && !fin; c++) begin
            out_ready = tog ? (c % 2 == 0) : 1'b1;
            in_valid = 1'b1;
            mem_out = bank(ib);
            if (chg >= 0 && ib >= 1) point = 3'(chg);
            #1;
            chk("done", done, dexp);
            if (dexp) begin
                chk("busy_end", busy, 0);
                fin = 1;
            end else begin
                chk("out_valid", out_valid, fc != 0);
                chk("in_ready", in_ready, ib < len && fc < 2);
                if (fc != 0) begin
                    chk("fft_in", fft_in, expv(p, m, ob));
                    chk("out_last", out_last, ob == len - 1);
                end
                a = ib < len && fc < 2;
                pp = fc != 0 && out_ready;
                dexp = pp && ob == len - 1;
                ib += int'(a);
                ob += int'(pp);
                fc += int'(a) - int'(pp);
                tick();
            end
        end
        if (!fin) chk("frame_timeout", 0, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic bad_start(input int p, input int len);
        point = 3'(p);
        frame_len = LW'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_busy", busy, 0);
        tick();
        chk("cfg_err_clear", cfg_err, 0);
        chk("cfg_err_idle", busy, 0);
    endtask

    task automatic abort(input bit use_rst);
        point = 3'd7;
        point_2_mode = 1'b0;
        frame_len = LW'(5);
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        mem_out = bank(0);
        tick();
        tick();
        chk("abort_full_ready", in_ready, 0);
        chk("abort_full_valid", out_valid, 1);
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_fft_in", fft_in, 0);
        tick();
        chk("abort_done2", done, 0);
        chk("abort_valid2", out_valid, 0);
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; point = '0; point_2_mode = 1'b0; frame_len = '0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mem_out = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_fft_in", fft_in, 0);
        rst = 1'b0;
        tick();
        run_frame(7, 0, 3, 0, -1);
        run_frame(2, 1, 4, 1, -1);
        run_frame(5, 0, 2, 0, -1);
        run_frame(3, 0, 2, 1, -1);
        run_frame(2, 0, 2, 0, -1);
        run_frame(4, 0, 3, 0, 3);
        bad_start(6, 3);
        bad_start(4, 0);
`ifdef FFT_IN_XBAR_BYPASS_EN
        run_frame(0, 0, 1, 0, -1);
`else
        bad_start(0, 1);
`endif
        abort(0);
        abort(1);
        run_frame(7, 0, 1, 1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_in_xbar.md
FFT_IN_XBAR -- requirements
Module: fft_in_xbar

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: bit width of one complex sample lane.
REQ-002 SHALL have parameter LEN_W, default 10: width of the frame-length field and the beat counter.
REQ-003 SHALL have ports clk (input, 1, sole clock) and rst (input, 1, reset); one clock, reset synchronous and active-high.
REQ-004 SHALL have ports start (in, 1, begin frame); point (in, 3, radix select); point_2_mode (in, 1, radix-2 4-pair mode); frame_len (in, LEN_W, beats per frame).
REQ-005 SHALL have ports flush (in, 1, abort frame); busy (out, 1, frame active); done (out, 1, one-cycle frame-complete pulse); cfg_err (out, 1, one-cycle start-rejected pulse).
REQ-006 SHALL have ports mem_out (in, 8*DATA_WIDTH, bank lanes 0..7, lane k at bits [k*DW +: DW]); in_valid (in, 1); in_ready (out, 1).
REQ-007 SHALL have ports fft_in (out, 12*DATA_WIDTH, PE lanes 0..11, same packing); out_valid (out, 1); out_ready (in, 1); out_last (out, 1, final beat of frame).

Function
REQ-008 SHALL implement states IDLE, RUN, DRAIN; start is sampled only in IDLE.
REQ-009 SHALL, in IDLE on start with point in {2,3,4,5,7} and frame_len!=0, latch point, point_2_mode and frame_len, then enter RUN next cycle; busy=1 in RUN and DRAIN.
REQ-010 SHALL, on start with any other point or frame_len==0, remain in IDLE and pulse cfg_err for one cycle.
REQ-011 SHALL hold the latched configuration constant for the whole frame; point/point_2_mode/frame_len changes during RUN/DRAIN SHALL have no effect.
REQ-012 SHALL accept a beat when in_valid && in_ready; in_ready = RUN && beats_accepted<frame_len && fifo_count<2.
REQ-013 SHALL remap each accepted beat before storing it into a 2-entry output FIFO; PE lanes not listed below SHALL be zero.
REQ-014 SHALL use mapping point 7: PE0..6 = bank 0,1,6,4,3,2,5.
REQ-015 SHALL use mapping point 5: PE0..4 = bank 0,1,4,3,2.
REQ-016 SHALL use mapping point 4: PE1=b0, PE2=b2, PE5=b1, PE6=b3.
REQ-017 SHALL use mapping point 3: PE0=b0, PE1=b1, PE2=b2, PE5=b4, PE6=b5, PE7=b3.
REQ-018 SHALL use mapping point 2: PE1=b0, PE2=b1, PE5=b2, PE6=b3, PE8=b4, PE9=b5; with point_2_mode=1 additionally PE10=b6, PE11=b7.
REQ-019 SHALL present the FIFO head on fft_in with out_valid=1 when the FIFO is non-empty; an accepted beat appears no earlier than the cycle after acceptance (1-cycle latency when the FIFO is empty).
REQ-020 SHALL pop the FIFO on out_valid && out_ready; simultaneous push and pop SHALL keep the count unchanged and preserve order.
REQ-021 SHALL hold fft_in, out_valid and out_last stable while out_valid && !out_ready.
REQ-022 SHALL assert out_last with the beat that was the frame_len-th accepted beat.
REQ-023 SHALL enter DRAIN after the frame_len-th beat is accepted, then IDLE with a one-cycle done pulse in the cycle after the last-beat pop.
REQ-024 SHALL, on flush in any state, empty the FIFO, clear the beat counter and enter IDLE next cycle without pulsing done; flush SHALL take priority over start and handshakes in the same cycle.

Reset
REQ-025 SHALL, on rst high at a clk edge, enter IDLE, empty the FIFO, clear the counter and latched configuration; busy, done, cfg_err, out_valid, out_last, in_ready SHALL be 0 and fft_in all-zero.
REQ-026 SHALL let rst asserted mid-frame discard all buffered beats; no done pulse SHALL follow.

Configuration
REQ-027 SHALL, with macro FFT_IN_XBAR_BYPASS_EN defined, accept point==0 as a legal identity mode: PE0..7 = bank 0..7, PE8..11 = 0.
REQ-028 SHALL, without FFT_IN_XBAR_BYPASS_EN, treat point==0 as illegal (cfg_err per REQ-010) and contain no bypass logic.

Verification
REQ-029 SHALL cover: point=7, frame_len=3, out_ready=1, bank k = k+1 -> 3 beats with fft_in lanes 0..6 = 1,2,7,5,4,3,6, lanes 7..11 = 0, out_last on beat 3, done one cycle after.
REQ-030 SHALL cover: point=2, point_2_mode=1, frame_len=4, out_ready toggling 1/0 -> PE10=b6, PE11=b7, in_ready low whenever the FIFO holds 2 entries, no beat lost or duplicated.
REQ-031 SHALL cover: start with point=6 or frame_len=0 -> cfg_err pulse, busy stays 0.
REQ-032 SHALL cover: point changed from 4 to 3 mid-frame -> all beats of the frame still use the point-4 mapping.
REQ-033 SHALL cover: flush asserted with 2 beats buffered and out_ready=0 -> out_valid=0 and busy=0 next cycle, no done pulse; rst mid-frame gives identical result.
REQ-034 SHALL cover: with FFT_IN_XBAR_BYPASS_EN, point=0 frame_len=1 -> PE0..7 equal bank 0..7; without it -> cfg_err.
